game_status_ctrl: RTL and testbench

GAME_STATUS_CTRL -- requirements
Module: game_status_ctrl

---
 rtl/game_status_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_status_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_status_ctrl.sv
// Game status controller: button synchronizer, IDLE/PLAY/DEAD state machine,
// pipe collision and pass detection, BCD score and LFSR-driven pipe length.
module game_status_ctrl #(
    parameter int         BIRD_X   = 100,
    parameter int         BIRD_W   = 34,
    parameter int         BIRD_H   = 24,
    parameter int         PIPE_W   = 90,
    parameter int         CAP_H    = 33,
    parameter int         GAP      = 150,
    parameter int         GROUND_Y = 428,
    parameter int         LONG_MIN = 40,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic        button_i,
    input  logic [15:0] bird_y_i,
    input  logic [15:0] pipes_position_i,
    output logic        status_o,
    output logic [15:0] pipes_long_o,
    output logic [7:0]  score_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic [16:0] BIRD_RIGHT = 17'(BIRD_X + BIRD_W);
    localparam logic [16:0] BIRD_LEFT  = 17'(BIRD_X);
    localparam logic [16:0] PIPE_W_E   = 17'(PIPE_W);
    localparam logic [16:0] CAP_H_E    = 17'(CAP_H);
    localparam logic [16:0] GAP_E      = 17'(GAP);
    localparam logic [16:0] BIRD_H_E   = 17'(BIRD_H);
    localparam logic [16:0] GROUND_E   = 17'(GROUND_Y);

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] long_from_lfsr(input logic [7:0] v);
        logic [7:0] l;
        l = (v >= 8'd200) ? (v - 8'd128) : v;
        return 16'(LONG_MIN) + {8'd0, l};
    endfunction

    logic        btn_meta_q, btn_sync_q, btn_prev_q;
    state_t      state_q, state_d;
    logic        status_q;
    logic [7:0]  score_q, score_d;
    logic [15:0] pipes_long_q, pipes_long_d;
    logic [7:0]  lfsr_q;
    logic        passed_q, passed_d;
    logic [15:0] prev_pos_q;

    logic        press_s, wrap_s, x_overlap_s, hit_s, cleared_s;
    logic [16:0] pos_s, bird_y_s, long_s;

    assign pos_s    = {1'b0, pipes_position_i};
    assign bird_y_s = {1'b0, bird_y_i};
    assign long_s   = {1'b0, pipes_long_q};

    assign press_s     = btn_prev_q & ~btn_sync_q;
    assign wrap_s      = pipes_position_i > prev_pos_q;
    assign x_overlap_s = (pos_s <= BIRD_RIGHT) && ((pos_s + PIPE_W_E) >= BIRD_LEFT);
    assign hit_s       = (x_overlap_s && ((bird_y_s <= (long_s + CAP_H_E)) ||
                                          ((bird_y_s + BIRD_H_E) >= (long_s + GAP_E)))) ||
                         ((bird_y_s + BIRD_H_E) >= GROUND_E);
    assign cleared_s   = (pos_s + PIPE_W_E) < BIRD_LEFT;

    // Next-state, score, pass flag and pipe length; everything holds outside PLAY.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        pipes_long_d = pipes_long_q;
        passed_d     = passed_q;
        case (state_q)
            ST_IDLE: begin
                if (press_s) begin
                    state_d  = ST_PLAY;
                    score_d  = 8'h00;
                    passed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // A hit on the same tick as a pass suppresses the score increment.
                if (tick_i && hit_s) begin
                    state_d = ST_DEAD;
                end else if (tick_i && cleared_s && !passed_q) begin
                    score_d = bcd_inc_sat(score_q);
                end else begin
                    score_d = score_q;
                end
                if (wrap_s) begin
                    passed_d     = 1'b0;
                    pipes_long_d = long_from_lfsr(lfsr_q);
                end else if (tick_i && cleared_s) begin
                    passed_d = 1'b1;
                end else begin
                    passed_d = passed_q;
                end
            end
            ST_DEAD: begin
                if (press_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_meta_q   <= 1'b1;
            btn_sync_q   <= 1'b1;
            btn_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            status_q     <= 1'b0;
            score_q      <= 8'h00;
            pipes_long_q <= 16'd100;
            lfsr_q       <= SEED;
            passed_q     <= 1'b0;
            prev_pos_q   <= 16'd640;
        end else begin
            btn_meta_q   <= button_i;
            btn_sync_q   <= btn_meta_q;
            btn_prev_q   <= btn_sync_q;
            state_q      <= state_d;
            status_q     <= (state_q == ST_PLAY);
            score_q      <= score_d;
            pipes_long_q <= pipes_long_d;
            lfsr_q       <= lfsr_next(lfsr_q);
            passed_q     <= passed_d;
            prev_pos_q   <= pipes_position_i;
        end
    end

    assign status_o     = status_q;
    assign pipes_long_o = pipes_long_q;
    assign score_o      = score_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Randomized and directed bench for game_status_ctrl, checked every cycle
// against a behavioural model built from the game rules.
module tb_game_status_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        button = 1'b1;
    logic [15:0] bird_y = 16'd200;
    logic [15:0] pos = 16'd640;
    logic        status;
    logic [15:0] pipes_long;
    logic [7:0]  score;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: plain integers, score kept in decimal.
    int m_state, m_status, m_score, m_long, m_lfsr, m_passed, m_prev;
    int m_sy[3];

    game_status_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .tick_i           (tick),
        .button_i         (button),
        .bird_y_i         (bird_y),
        .pipes_position_i (pos),
        .status_o         (status),
        .pipes_long_o     (pipes_long),
        .score_o          (score),
        .state_o          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_status = 0; m_score = 0; m_long = 100;
        m_lfsr = 165; m_passed = 0; m_prev = 640;
        for (int i = 0; i < 3; i++) m_sy[i] = 1;
    endtask

    task automatic model_clock();
        int p, by, xo, hit, cleared, press, wrap, l, new_status;
        p  = int'(pos);
        by = int'(bird_y);
        press   = (m_sy[2] == 1 && m_sy[1] == 0);
        wrap    = (p > m_prev);
        xo      = (p <= 134) && (p + 90 >= 100);
        hit     = (xo && (by <= m_long + 33 || by + 24 >= m_long + 150)) || (by + 24 >= 428);
        cleared = (p + 90 < 100);
        new_status = (m_state == 1);
        if (m_state == 0) begin
            if (press) begin m_state = 1; m_score = 0; m_passed = 0; end
        end else if (m_state == 1) begin
            l = m_lfsr;
            if (tick) begin
                if (hit) m_state = 2;
                else if (cleared && !m_passed) m_score = (m_score < 99) ? m_score + 1 : 99;
                if (cleared) m_passed = 1;
            end
            if (wrap) begin
                m_passed = 0;
                m_long = 40 + ((l >= 200) ? l - 128 : l);
            end
        end else begin
            if (press) m_state = 0;
        end
        m_lfsr = ((m_lfsr * 2) % 256) + ($countones(8'(m_lfsr) & 8'hB8) % 2);
        m_prev = p;
        m_sy[2] = m_sy[1]; m_sy[1] = m_sy[0]; m_sy[0] = int'(button);
        m_status = new_status;
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("status", 32'(status), 32'(m_status));
        check("score", 32'(score), 32'((m_score / 10) * 16 + (m_score % 10)));
        check("pipes_long", 32'(pipes_long), 32'(m_long));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press_once();
        button = 1'b0;
        repeat (4) step();
        button = 1'b1;
        repeat (3) step();
    endtask

    task automatic go_play();
        for (int i = 0; i < 3; i++) begin
            if (m_state != 1) press_once();
        end
        check("in_play", 32'(state), 32'd1);
    endtask

    initial begin
        bit ok;
        int d;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_long", 32'(pipes_long), 32'd100);
        step();
        rst = 1'b0;

        // Idle with ticks and the button released.
        for (int i = 0; i < 100; i++) begin tick = 1'b1; step(); end
        tick = 1'b0;
        check("idle_state", 32'(state), 32'd0);
        check("idle_long", 32'(pipes_long), 32'd100);

        // Press enters PLAY within 4 clocks, status follows one clock later.
        button = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (state == 2'b01) begin ok = 1'b1; break; end
        end
        check("press_to_play", 32'(ok), 32'd1);
        step();
        check("status_after_play", 32'(status), 32'd1);
        check("play_score", 32'(score), 32'd0);

        // Top-pipe collision.
        bird_y = 16'd120; pos = 16'd110; tick = 1'b1;
        step();
        tick = 1'b0;
        check("hit_dead", 32'(state), 32'd2);
        step();
        check("dead_status", 32'(status), 32'd0);
        check("dead_score", 32'(score), 32'd0);
        button = 1'b1;
        repeat (3) step();

        // Clean pass through the gap scores one point at position 9.
        bird_y = 16'd200; pos = 16'd130;
        go_play();
        for (int p = 120; p >= 9; p--) begin
            pos = 16'(p); tick = 1'b1; step();
        end
        tick = 1'b0;
        check("pass_score", 32'(score), 32'h01);
        check("pass_state", 32'(state), 32'd1);
        check("pass_long", 32'(pipes_long), 32'd100);

        // Ground collision.
        bird_y = 16'd410; tick = 1'b1;
        step();
        tick = 1'b0;
        check("ground_dead", 32'(state), 32'd2);

        // Score saturation at 99.
        bird_y = 16'd200;
        go_play();
        tick = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pos = 16'd640; step();
            pos = 16'd5;   step();
        end
        tick = 1'b0;
        check("score_sat", 32'(score), 32'h99);

        // Wrap reload range.
        pos = 16'd0;   step();
        pos = 16'd640; step();
        check("wrap_range", 32'(pipes_long >= 16'd40 && pipes_long <= 16'd239), 32'd1);

        // Reset mid-game with a press in the synchronizer.
        button = 1'b0;
        step();
        #2 rst = 1'b1; button = 1'b1;
        model_reset();
        #1;
        check("rst_play_state", 32'(state), 32'd0);
        check("rst_play_status", 32'(status), 32'd0);
        check("rst_play_score", 32'(score), 32'd0);
        check("rst_play_long", 32'(pipes_long), 32'd100);
        step();
        rst = 1'b0;
        repeat (6) step();
        check("press_discarded", 32'(state), 32'd0);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            tick = 1'($urandom % 2);
            if ($urandom_range(0, 14) == 0) button = ~button;
            bird_y = ($urandom_range(0, 99) < 5) ? 16'($urandom_range(400, 460))
                                                 : 16'($urandom_range(60, 300));
            if (pos == 16'd0 || $urandom_range(0, 199) == 0) begin
                pos = 16'd640;
            end else begin
                d = $urandom_range(0, 6);
                pos = (int'(pos) > d) ? 16'(int'(pos) - d) : 16'd0;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                #1 model_reset();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
